mem_bus_interface: RTL and testbench

Bus-cycle sequencer directly downstream of the top-level memory control stage. It accepts one load/store request at a time (address, write data, RW) and runs a handshaked cycle to the data RAM/peripheral bus, inserting wait states until the RAM asserts ready. It returns read data on the load-data path and pulses ack when the cycle completes. Word-addressed, 32-bit data.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_wdog.sv | 29 ++
 rtl/mem_bus_interface.sv | 110 +++++++++++
 tb/tb_mem_bus_interface.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus sequencer: FSM encoding, access
// direction codes and the default watchdog limit.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_bus_wdog.sv
// Bus-cycle watchdog: 8-bit counter cleared when a request is accepted,
// advanced on every stalled bus cycle, flagging the final permitted cycle.
module mem_bus_wdog
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_interface.sv
// Single-outstanding load/store bus sequencer with wait-state handling.
// Optional bus-cycle timeout is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_interface
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bus_interface: TIMEOUT must lie in 2..255");
    end

    state_t state, next_state;
    logic   bus_active;
    logic   next_active;
    logic   accept;
    logic   expire;

    assign bus_active  = (state == ISSUE) || (state == WAIT);
    assign next_active = (next_state == ISSUE) || (next_state == WAIT);
    assign accept      = (state == IDLE) && req;

`ifdef MEM_BUS_TIMEOUT_EN
    mem_bus_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .inc    (bus_active && !mem_ready),
        .expire (expire)
    );

    // err marks an abort: the final permitted cycle passed without mem_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= bus_active && !mem_ready && expire;
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (req) next_state = ISSUE;
            ISSUE, WAIT: begin
                if (mem_ready || expire) next_state = RESP;
                else                     next_state = WAIT;
            end
            RESP:        next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ack       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state  <= next_state;
            busy   <= (next_state != IDLE);
            ack    <= (next_state == RESP);
            mem_en <= next_active;

            if (accept) begin
                mem_we    <= (rw == RW_WRITE);
                mem_addr  <= addr & ~ADDR_W'(3);
                mem_wdata <= wdata;
            end else if (!next_active) begin
                mem_we <= 1'b0;
            end

            if (bus_active && mem_ready && (mem_we == RW_READ)) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed plus randomized transaction bench for mem_bus_interface,
// checked against a transaction-level model of the bus cycle.
module tb_mem_bus_interface;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TO       = 4;
    localparam int MAX_WAIT = 3;
`else
    localparam int TO       = 15;
    localparam int MAX_WAIT = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] rdata_exp   = 32'd0;

    mem_bus_interface #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: request at cycle 0, bus active for waits+1 cycles,
    // ack in the following cycle, then back to idle.
    task automatic do_txn(input logic t_rw, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input int waits,
                          input logic [31:0] t_rdata);
        logic [31:0] exp_addr;
        exp_addr  = t_addr & 32'hFFFF_FFFC;
        req       = 1'b1;
        rw        = t_rw;
        addr      = t_addr;
        wdata     = t_wdata;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        req   = 1'b0;
        addr  = (t_addr == 32'h103) ? 32'h500 : $urandom;
        wdata = $urandom;
        rw    = 1'($urandom);
        for (int c = 0; c <= waits; c++) begin
            chk("bus_en",    32'(mem_en), 32'd1);
            chk("bus_we",    32'(mem_we), 32'(t_rw));
            chk("bus_addr",  mem_addr, exp_addr);
            chk("bus_wdata", mem_wdata, t_wdata);
            chk("bus_busy",  32'(busy), 32'd1);
            chk("bus_noack", 32'(ack), 32'd0);
            mem_ready = (c == waits);
            mem_rdata = (c == waits) ? t_rdata : $urandom;
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (t_rw == 1'b0) rdata_exp = t_rdata;
        chk("resp_ack",   32'(ack), 32'd1);
        chk("resp_err",   32'(err), 32'd0);
        chk("resp_en",    32'(mem_en), 32'd0);
        chk("resp_we",    32'(mem_we), 32'd0);
        chk("resp_busy",  32'(busy), 32'd1);
        chk("resp_rdata", rdata, rdata_exp);
        tick();
        chk("post_ack",  32'(ack), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] d [3];

        rst_n     = 1'b0;
        req       = 1'b0;
        rw        = 1'b0;
        addr      = 32'hFFFF_FFFF;
        wdata     = 32'hFFFF_FFFF;
        mem_ready = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ack",   32'(ack), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_en",    32'(mem_en), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed: zero-wait read, 3-wait write, misaligned read with addr changing
        do_txn(1'b0, 32'h100, 32'h0, 0, 32'h1234_5678);
        do_txn(1'b1, 32'h204, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h103, 32'h0, 2, 32'hA5A5_0103);
`ifndef MEM_BUS_TIMEOUT_EN
        do_txn(1'b0, 32'h7F8, 32'h0, 20, 32'h0BAD_CAFE);
`endif

        // Randomized transactions
        for (int i = 0; i < 30; i++) begin
            do_txn(1'($urandom), $urandom, $urandom,
                   $urandom_range(0, MAX_WAIT), $urandom);
        end

        // Reset during the second wait cycle abandons the access
        req   = 1'b1;
        rw    = 1'b0;
        addr  = 32'h300;
        mem_ready = 1'b0;
        tick();
        req = 1'b0;
        tick();
        chk("rstw_en", 32'(mem_en), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstw_en",    32'(mem_en), 32'd0);
        chk("rstw_busy",  32'(busy), 32'd0);
        chk("rstw_rdata", rdata, 32'd0);
        chk("rstw_ack",   32'(ack), 32'd0);
        rdata_exp = 32'd0;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstw_noack", 32'(ack), 32'd0);
            chk("rstw_idle",  32'(busy), 32'd0);
        end
        mem_ready = 1'b0;

        // Back-to-back: req held, mem_ready held; acks three cycles apart
        for (int k = 0; k < 3; k++) d[k] = $urandom;
        rw        = 1'b0;
        addr      = 32'h80;
        mem_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            req       = (t <= 6);
            mem_rdata = (t < 9) ? d[t / 3] : 32'd0;
            chk("b2b_ack", 32'(ack), 32'((t == 2) || (t == 5) || (t == 8)));
            if (t == 2 || t == 5 || t == 8) begin
                rdata_exp = d[(t - 2) / 3];
                chk("b2b_rdata", rdata, rdata_exp);
            end
            tick();
        end
        req       = 1'b0;
        mem_ready = 1'b0;
        chk("b2b_idle", 32'(busy), 32'd0);
        tick();

`ifdef MEM_BUS_TIMEOUT_EN
        // Timeout abort with mem_ready never asserted
        req   = 1'b1;
        rw    = 1'b0;
        addr  = 32'h40;
        mem_ready = 1'b0;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("to_en",    32'(mem_en), 32'd1);
            chk("to_noack", 32'(ack), 32'd0);
            tick();
        end
        chk("to_ack",   32'(ack), 32'd1);
        chk("to_err",   32'(err), 32'd1);
        chk("to_en",    32'(mem_en), 32'd0);
        chk("to_rdata", rdata, rdata_exp);
        tick();
        chk("to_errclr", 32'(err), 32'd0);
        chk("to_idle",   32'(busy), 32'd0);
        // mem_ready on the final permitted cycle completes normally
        do_txn(1'b0, 32'h44, 32'h0, 3, 32'h5A5A_0044);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
